// File: rtl/repair_sb_arbiter.sv
// repair_sb_arbiter: round-robin owner of the MBTRAIN REPAIR sideband tx channel.
// Ports: clk, rst_n (async, active low), i_en (REPAIR substate enable),
//        i_valid_tx/i_msg_tx/i_data_tx (tx-side request), i_valid_rx/i_msg_rx
//        (rx-side request), i_sb_busy (sideband busy); o_sb_valid/o_sb_message/
//        o_sb_data (to sideband), o_grant_tx/o_grant_rx (current owner),
//        o_busy_negedge_tx/o_busy_negedge_rx (done pulses), o_timeout.
// Optional: define REPAIR_SB_ARB_TIMEOUT_EN to abort a transfer that has not
//        completed TIMEOUT_CYCLES cycles after its grant.
module repair_sb_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd8000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_valid_tx,
  input  logic [3:0] i_msg_tx,
  input  logic [2:0] i_data_tx,
  input  logic       i_valid_rx,
  input  logic [3:0] i_msg_rx,
  input  logic       i_sb_busy,
  output logic       o_sb_valid,
  output logic [3:0] o_sb_message,
  output logic [2:0] o_sb_data,
  output logic       o_grant_tx,
  output logic       o_grant_rx,
  output logic       o_busy_negedge_tx,
  output logic       o_busy_negedge_rx,
  output logic       o_timeout
);

  typedef enum logic [2:0] {
    S_DISABLED,
    S_ARB,
    S_ISSUE,
    S_WAIT_DONE,
    S_COOLDOWN
  } state_e;

  state_e     state_q, state_d;
  logic       busy_q;
  logic       rr_rx_q, rr_rx_d;
  logic       valid_q, valid_d;
  logic [3:0] msg_q, msg_d;
  logic [2:0] data_q, data_d;
  logic       gnt_tx_q, gnt_tx_d;
  logic       gnt_rx_q, gnt_rx_d;
  logic       done_tx_q, done_tx_d;
  logic       done_rx_q, done_rx_d;
  logic       busy_fall;
  logic       pick_tx;
  logic       pick_rx;

`ifdef REPAIR_SB_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 16'd1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, CNT_W};
`endif

  assign busy_fall = busy_q & ~i_sb_busy;

  // rr_rx_q=1 means rx was served last, so tx wins a tie.
  assign pick_tx = i_valid_tx & (~i_valid_rx | rr_rx_q);
  assign pick_rx = i_valid_rx & (~i_valid_tx | ~rr_rx_q);

  always_comb begin
    state_d   = state_q;
    rr_rx_d   = rr_rx_q;
    valid_d   = valid_q;
    msg_d     = msg_q;
    data_d    = data_q;
    gnt_tx_d  = gnt_tx_q;
    gnt_rx_d  = gnt_rx_q;
    done_tx_d = 1'b0;
    done_rx_d = 1'b0;
`ifdef REPAIR_SB_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    tmo_d     = 1'b0;
`endif
    if (!i_en) begin
      // Abort: drop everything, no done pulse, keep rr_rx.
      state_d  = S_DISABLED;
      valid_d  = 1'b0;
      msg_d    = 4'd0;
      data_d   = 3'd0;
      gnt_tx_d = 1'b0;
      gnt_rx_d = 1'b0;
`ifdef REPAIR_SB_ARB_TIMEOUT_EN
      cnt_d    = '0;
`endif
    end else begin
      unique case (state_q)
        S_DISABLED: begin
          state_d = S_ARB;
        end
        S_ARB: begin
          unique case (1'b1)
            pick_tx: begin
              msg_d    = i_msg_tx;
              data_d   = i_data_tx;
              gnt_tx_d = 1'b1;
              valid_d  = 1'b1;
              rr_rx_d  = 1'b0;
              state_d  = S_ISSUE;
`ifdef REPAIR_SB_ARB_TIMEOUT_EN
              cnt_d    = '0;
`endif
            end
            pick_rx: begin
              msg_d    = i_msg_rx;
              data_d   = 3'd0;
              gnt_rx_d = 1'b1;
              valid_d  = 1'b1;
              rr_rx_d  = 1'b1;
              state_d  = S_ISSUE;
`ifdef REPAIR_SB_ARB_TIMEOUT_EN
              cnt_d    = '0;
`endif
            end
            default: begin
            end
          endcase
        end
        S_ISSUE: begin
          if (i_sb_busy) begin
            valid_d = 1'b0;
            state_d = S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (busy_fall) begin
            done_tx_d = gnt_tx_q;
            done_rx_d = gnt_rx_q;
            gnt_tx_d  = 1'b0;
            gnt_rx_d  = 1'b0;
            msg_d     = 4'd0;
            data_d    = 3'd0;
            state_d   = S_COOLDOWN;
          end
        end
        S_COOLDOWN: begin
          // One idle cycle lets the served side drop its valid.
          state_d = S_ARB;
        end
        default: begin
          state_d = S_DISABLED;
        end
      endcase
`ifdef REPAIR_SB_ARB_TIMEOUT_EN
      if (state_q == S_ISSUE || state_q == S_WAIT_DONE) begin
        if (cnt_q == TMO_LAST) begin
          tmo_d     = 1'b1;
          valid_d   = 1'b0;
          gnt_tx_d  = 1'b0;
          gnt_rx_d  = 1'b0;
          msg_d     = 4'd0;
          data_d    = 3'd0;
          done_tx_d = 1'b0;
          done_rx_d = 1'b0;
          state_d   = S_COOLDOWN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_DISABLED;
      busy_q    <= 1'b0;
      rr_rx_q   <= 1'b1;
      valid_q   <= 1'b0;
      msg_q     <= 4'd0;
      data_q    <= 3'd0;
      gnt_tx_q  <= 1'b0;
      gnt_rx_q  <= 1'b0;
      done_tx_q <= 1'b0;
      done_rx_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= i_sb_busy;
      rr_rx_q   <= rr_rx_d;
      valid_q   <= valid_d;
      msg_q     <= msg_d;
      data_q    <= data_d;
      gnt_tx_q  <= gnt_tx_d;
      gnt_rx_q  <= gnt_rx_d;
      done_tx_q <= done_tx_d;
      done_rx_q <= done_rx_d;
    end
  end

`ifdef REPAIR_SB_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign o_timeout = tmo_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_sb_valid        = valid_q;
  assign o_sb_message      = msg_q;
  assign o_sb_data         = data_q;
  assign o_grant_tx        = gnt_tx_q;
  assign o_grant_rx        = gnt_rx_q;
  assign o_busy_negedge_tx = done_tx_q;
  assign o_busy_negedge_rx = done_rx_q;

endmodule

// File: doc/repair_sb_arbiter.md
Name: repair_sb_arbiter

Overview:
- Shares the single MBTRAIN sideband transmit channel between the REPAIR tx-side and rx-side sub-FSMs.
- Grants one requester at a time using round-robin and latches that requester's message and lane encoding.
- Drives the sideband valid until the sideband accepts it, then reports completion back to the granted requester only.
- Sits between the repair tx/rx FSMs and the sideband wrapper, inside the MBTRAIN REPAIR substate.

Parameters:
- TIMEOUT_CYCLES, 16'd8000: cycles allowed from grant until busy falls; only used when the timeout macro is enabled.
- CNT_W, 16: width of the timeout counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- i_en  in  1  REPAIR substate enable from mbtrain
- i_valid_tx  in  1  tx-side request; held high until its done pulse
- i_msg_tx  in  4  tx-side sideband message code
- i_data_tx  in  3  tx-side lanes encoding
- i_valid_rx  in  1  rx-side request; held high until its done pulse
- i_msg_rx  in  4  rx-side sideband message code
- i_sb_busy  in  1  sideband busy (high while a message is in flight)
- o_sb_valid  out  1  message valid to sideband
- o_sb_message  out  4  granted message code
- o_sb_data  out  3  granted lanes encoding (3'b000 for rx grants)
- o_grant_tx  out  1  tx currently owns the channel
- o_grant_rx  out  1  rx currently owns the channel
- o_busy_negedge_tx  out  1  one-cycle done pulse to tx
- o_busy_negedge_rx  out  1  one-cycle done pulse to rx
- o_timeout  out  1  one-cycle timeout pulse (tied 0 when the macro is off)

Behaviour:
- Reset: all outputs are 0; state is DISABLED; busy_q=0; rr_last=RX, so TX wins first; counter=0.
- busy_fall = busy_q & ~i_sb_busy, where busy_q is i_sb_busy registered every cycle regardless of state.
- DISABLED: all outputs 0. When i_en=1, go to ARB.
- ARB:
  - Only one requester valid: grant it.
  - Both valid: grant the one not equal to rr_last.
  - On grant, in the same edge: latch msg/data into o_sb_message/o_sb_data, set o_grant_x=1, set o_sb_valid=1, set rr_last=granted, clear counter, go to ISSUE.
  - Latency: valid sampled at cycle n gives o_sb_valid=1 at n+1.
- ISSUE: hold o_sb_valid=1. When i_sb_busy=1, clear o_sb_valid and go to WAIT_DONE.
- WAIT_DONE: on busy_fall:
  - pulse o_busy_negedge_x for exactly one cycle, for the granted x only;
  - clear o_grant_x and o_sb_message/o_sb_data to 0;
  - go to COOLDOWN.
- COOLDOWN: exactly one cycle with no grant, then ARB. This lets the completed requester drop its valid, so a stale valid is never re-granted.
- Message/data are frozen from grant until COOLDOWN; input changes while granted are ignored.
- A request whose valid drops before it is granted is simply not served; no pulse is issued.
- i_en=0 in any state: at the next edge go to DISABLED and clear all outputs. No done pulse is issued for the aborted transfer. rr_last is kept.
- Never both grants high; never both done pulses in the same cycle.
- Busy high for only one cycle still completes: seen in ISSUE, busy_fall in WAIT_DONE on the next cycle.

Optional Feature:
- Macro: REPAIR_SB_ARB_TIMEOUT_EN.
- When defined:
  - The counter increments each cycle in ISSUE and WAIT_DONE.
  - When count reaches TIMEOUT_CYCLES-1: pulse o_timeout for one cycle, drop o_sb_valid and the grant, send no done pulse, go to COOLDOWN.
  - rr_last still advances.
- When undefined: no counter logic; o_timeout is tied 0; the arbiter waits indefinitely in ISSUE/WAIT_DONE.

Test Plan:
- Single rx request: i_en=1, i_valid_rx=1, msg 4'b0010; i_sb_busy high 3 cycles starting 2 cycles after o_sb_valid.
  -> o_sb_valid=1 one cycle after the request, o_sb_message=4'b0010, o_grant_rx=1; o_sb_valid clears the cycle after busy rises; o_busy_negedge_rx pulses one cycle after busy falls; no tx pulse.
- Simultaneous tx (4'b0111, data 3'b011) and rx (4'b1000) from reset.
  -> tx is served first with o_sb_data=3'b011; rx is granted in ARB after the tx COOLDOWN with o_sb_data=3'b000.
- Fairness: tx and rx both held continuously.
  -> grants strictly alternate TX, RX, TX, RX; never two consecutive grants to the same requester.
- Disable mid-transfer: i_en drops while in WAIT_DONE.
  -> next cycle all outputs are 0 and no done pulse; after re-enable with both requests valid, the requester not equal to rr_last is granted.
- Busy one-cycle blip during ISSUE.
  -> transfer completes with exactly one done pulse, 2 cycles after the busy rise.
- With REPAIR_SB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, busy never asserts.
  -> o_timeout pulses 16 cycles after grant, o_sb_valid=0, no done pulse; ARB resumes after one cycle.
